// File: rtl/q100_dtcm_loader.sv
// q100_dtcm_loader: owns the DTCM SRAM port of q100_core.
// Holds the core in reset while a host image is streamed into DTCM, then
// hands DTCM to the core. On done_intr it takes DTCM back and streams a
// result window to the host through a 2-entry skid FIFO.
// Optional: define Q100_DTCM_LOADER_CKSUM_EN for a running load checksum.
module q100_dtcm_loader #(
  parameter int DTCM_ADDR_WIDTH = 12,
  parameter int DTCM_DATA_WIDTH = 32,
  parameter int DTCM_BANK       = DTCM_DATA_WIDTH/8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [DTCM_ADDR_WIDTH:0]   load_len_i,
  input  logic [DTCM_ADDR_WIDTH-1:0] dump_base_i,
  input  logic [DTCM_ADDR_WIDTH:0]   dump_len_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [DTCM_DATA_WIDTH-1:0] s_data_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DTCM_DATA_WIDTH-1:0] m_data_o,
  output logic                       core_rst_o,
  input  logic                       done_intr_i,
  input  logic [DTCM_ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DTCM_BANK-1:0]       core_we_i,
  input  logic [DTCM_DATA_WIDTH-1:0] core_data_i,
  output logic [DTCM_DATA_WIDTH-1:0] core_data_o,
  output logic [DTCM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DTCM_BANK-1:0]       mem_we_o,
  output logic [DTCM_DATA_WIDTH-1:0] mem_data_o,
  input  logic [DTCM_DATA_WIDTH-1:0] mem_data_i,
  output logic                       busy_o,
  output logic [DTCM_DATA_WIDTH-1:0] cksum_o
);

  localparam int AW = DTCM_ADDR_WIDTH;
  localparam int DW = DTCM_DATA_WIDTH;
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;     // load beats written / dump reads issued
  logic [LW-1:0]   acc_q, acc_d;     // dump words accepted by host
  logic [LW-1:0]   load_len_q, dump_len_q;
  logic [AW-1:0]   dump_base_q;
  logic [LW-1:0]   load_len_clamp;

  // dump read path: one read in flight at most, 2-entry output FIFO
  logic            rd_pend_q;
  logic [DW-1:0]   fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      occ_q;
  logic [1:0]      slots;

  logic            beat, last_beat, pop, issue, last_acc, start_ok;

  assign start_ok       = (state_q == IDLE) && start_i;
  assign load_len_clamp = (load_len_i > MAX_LEN) ? MAX_LEN : load_len_i;

  assign s_ready_o  = (state_q == LOAD);
  assign beat       = s_ready_o && s_valid_i;
  assign last_beat  = beat && ((cnt_q + LW'(1)) == load_len_q);

  assign m_valid_o  = (occ_q != 2'd0);
  assign m_data_o   = fifo_q[rd_ptr_q];
  assign pop        = m_valid_o && m_ready_i;
  assign last_acc   = pop && ((acc_q + LW'(1)) == dump_len_q);

  // a word popped this cycle frees its slot, which keeps 1 word/cycle
  // streaming without ever overrunning the FIFO
  assign slots      = occ_q - {1'b0, pop} + {1'b0, rd_pend_q};
  assign issue      = (state_q == DUMP) && (cnt_q < dump_len_q) && (slots < 2'd2);

  assign core_rst_o = (state_q != RUN);
  assign busy_o     = (state_q != IDLE);

  // state and counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        cnt_d   = '0;
        acc_d   = '0;
        state_d = (load_len_i == '0) ? RUN : LOAD;
      end
      LOAD: if (beat) begin
        cnt_d = cnt_q + LW'(1);
        if (last_beat) state_d = RUN;
      end
      RUN: if (done_intr_i) begin
        cnt_d   = '0;
        acc_d   = '0;
        state_d = (dump_len_q == '0) ? IDLE : DUMP;
      end
      DUMP: begin
        if (issue) cnt_d = cnt_q + LW'(1);
        if (pop)   acc_d = acc_q + LW'(1);
        if (last_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // job parameters captured on an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_len_q  <= '0;
      dump_len_q  <= '0;
      dump_base_q <= '0;
    end else if (start_ok) begin
      load_len_q  <= load_len_clamp;
      dump_len_q  <= dump_len_i;
      dump_base_q <= dump_base_i;
    end
  end

  // dump read tracking and output FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      rd_pend_q <= issue;
      if (rd_pend_q) begin
        fifo_q[wr_ptr_q] <= mem_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
    end
  end

  // SRAM port mux: loader, core pass-through, or dump reader
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = '0;
    mem_data_o  = '0;
    core_data_o = '0;
    unique case (state_q)
      LOAD: begin
        mem_addr_o = cnt_q[AW-1:0];
        mem_we_o   = beat ? {DTCM_BANK{1'b1}} : '0;
        mem_data_o = s_data_i;
      end
      RUN: begin
        mem_addr_o  = core_addr_i;
        mem_we_o    = core_we_i;
        mem_data_o  = core_data_i;
        core_data_o = mem_data_i;
      end
      DUMP: mem_addr_o = dump_base_q + cnt_q[AW-1:0];
      default: ;
    endcase
  end

`ifdef Q100_DTCM_LOADER_CKSUM_EN
  logic [DW-1:0] cksum_q;

  // running sum of accepted load words, cleared per job
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cksum_q <= '0;
    else if (start_ok) cksum_q <= '0;
    else if (beat)     cksum_q <= cksum_q + s_data_i;
  end

  assign cksum_o = cksum_q;
`else
  assign cksum_o = '0;
`endif

endmodule

// File: tb/tb_q100_dtcm_loader.sv
// Directed bench for q100_dtcm_loader with a behavioural 1-cycle SRAM.
module tb_q100_dtcm_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [12:0] load_len_i = '0;
  logic [11:0] dump_base_i = '0;
  logic [12:0] dump_len_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_data_i = '0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_data_o;
  logic        core_rst_o;
  logic        done_intr_i = 1'b0;
  logic [11:0] core_addr_i = '0;
  logic [3:0]  core_we_i = '0;
  logic [31:0] core_data_i = '0;
  logic [31:0] core_data_o;
  logic [11:0] mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i = '0;
  logic        busy_o;
  logic [31:0] cksum_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] sram [4096];

  always #5 clk = ~clk;

  q100_dtcm_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .load_len_i(load_len_i),
    .dump_base_i(dump_base_i), .dump_len_i(dump_len_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .core_rst_o(core_rst_o), .done_intr_i(done_intr_i),
    .core_addr_i(core_addr_i), .core_we_i(core_we_i), .core_data_i(core_data_i),
    .core_data_o(core_data_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .busy_o(busy_o),
    .cksum_o(cksum_o)
  );

  // SRAM model: byte-lane writes, registered read data
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
    mem_data_i <= sram[mem_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, act, exp);
    end
  endtask

  // called at posedge+1 of the first DUMP cycle; checks order, holds,
  // count, latency and (when full) back-to-back throughput
  task automatic dump_chk(input string tag, input int n, input logic [3:0] pat,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ex [4];
    logic [31:0] hd;
    logic held;
    int got, cyc, first;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    got = 0; cyc = 0; first = -1; held = 1'b0; hd = '0;
    while (got < n && cyc < 80) begin
      m_ready_i = pat[cyc % 4];
      @(negedge clk);
      if (cyc == 0) begin
        chk({tag, "_core_rst"}, {31'b0, core_rst_o}, 32'd1);
        chk({tag, "_we_ignored"}, {28'b0, mem_we_o}, 32'd0);
      end
      if (m_valid_o) begin
        if (first < 0) first = cyc;
        if (held) chk({tag, "_hold"}, m_data_o, hd);
        if (m_ready_i) begin
          chk($sformatf("%s_w%0d", tag, got), m_data_o, ex[got]);
          got++;
        end
      end
      held = m_valid_o && !m_ready_i;
      hd   = m_data_o;
      @(posedge clk); #1;
      cyc++;
    end
    m_ready_i = 1'b0;
    chk({tag, "_count"}, got, n);
    chk({tag, "_latency"}, {31'b0, first >= 2}, 32'd1);
    if (pat == 4'b1111) chk({tag, "_tput"}, cyc, first + n);
    @(negedge clk);
    chk({tag, "_idle_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_idle_mvalid"}, {31'b0, m_valid_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    for (int i = 0; i < 4096; i++) sram[i] = '0;
    sram[12'h100] = 32'h12345678;
    sram[12'h101] = 32'hA5A5A5A5;
    sram[12'h102] = 32'h0BADF00D;
    sram[12'hFFE] = 32'hCAFE0001;
    sram[12'hFFF] = 32'hCAFE0002;

    // reset state
    #12;
    chk("rst_core_rst", {31'b0, core_rst_o}, 32'd1);
    chk("rst_busy",     {31'b0, busy_o},     32'd0);
    chk("rst_s_ready",  {31'b0, s_ready_o},  32'd0);
    chk("rst_m_valid",  {31'b0, m_valid_o},  32'd0);
    chk("rst_m_data",   m_data_o,            32'd0);
    chk("rst_mem_we",   {28'b0, mem_we_o},   32'd0);
    chk("rst_mem_addr", {20'b0, mem_addr_o}, 32'd0);
    chk("rst_mem_data", mem_data_o,          32'd0);
    chk("rst_cksum",    cksum_o,             32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // load 4 words; start_i raised with the final beat must be ignored
    load_len_i = 13'd4; dump_base_i = 12'h100; dump_len_i = 13'd3; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1; s_data_i = w[i];
      if (i == 3) start_i = 1'b1;
      @(negedge clk);
      chk($sformatf("load_addr%0d", i), {20'b0, mem_addr_o}, i);
      chk($sformatf("load_we%0d", i), {28'b0, mem_we_o}, 32'hF);
      chk($sformatf("load_data%0d", i), mem_data_o, w[i]);
      chk($sformatf("load_rdy%0d", i), {31'b0, s_ready_o}, 32'd1);
      chk($sformatf("load_core_rst%0d", i), {31'b0, core_rst_o}, 32'd1);
      @(posedge clk); #1;
    end
    s_valid_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("run_core_rst", {31'b0, core_rst_o}, 32'd0);
    chk("run_s_ready",  {31'b0, s_ready_o},  32'd0);
    chk("run_busy",     {31'b0, busy_o},     32'd1);
    chk("sram3",        sram[3],             32'h44);
`ifdef Q100_DTCM_LOADER_CKSUM_EN
    chk("cksum", cksum_o, 32'hAA);
`else
    chk("cksum", cksum_o, 32'h0);
`endif
    @(posedge clk); #1;

    // core pass-through write then read
    core_addr_i = 12'h100; core_we_i = 4'b0011; core_data_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("pt_addr", {20'b0, mem_addr_o}, 32'h100);
    chk("pt_we",   {28'b0, mem_we_o},   32'h3);
    chk("pt_data", mem_data_o,          32'hDEADBEEF);
    @(posedge clk); #1 core_we_i = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pt_rdata", core_data_o, 32'h1234BEEF);
    @(posedge clk); #1;

    // done -> dump 3 words under backpressure 1,0,0,1
    done_intr_i = 1'b1; core_addr_i = 12'h0;
    @(posedge clk); #1 done_intr_i = 1'b0; core_we_i = 4'hF;
    dump_chk("dump_bp", 3, 4'b1001, 32'h1234BEEF, 32'hA5A5A5A5, 32'h0BADF00D, 32'h0);
    core_we_i = 4'h0;

    // wrap: no load, dump 4 from 0xFFE at full rate
    load_len_i = 13'd0; dump_base_i = 12'hFFE; dump_len_i = 13'd4; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("wrap_run_core_rst", {31'b0, core_rst_o}, 32'd0);
    chk("wrap_s_ready",      {31'b0, s_ready_o},  32'd0);
    @(posedge clk); #1 done_intr_i = 1'b1;
    @(posedge clk); #1 done_intr_i = 1'b0;
    dump_chk("dump_wrap", 4, 4'b1111, 32'hCAFE0001, 32'hCAFE0002, 32'h11, 32'h22);

    // zero lengths: start -> RUN -> IDLE with no output
    load_len_i = 13'd0; dump_len_i = 13'd0; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("zero_core_rst", {31'b0, core_rst_o}, 32'd0);
    chk("zero_busy",     {31'b0, busy_o},     32'd1);
    @(posedge clk); #1 done_intr_i = 1'b1;
    @(posedge clk); #1 done_intr_i = 1'b0;
    @(negedge clk);
    chk("zero_idle_busy", {31'b0, busy_o},     32'd0);
    chk("zero_idle_crst", {31'b0, core_rst_o}, 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("zero_no_mvalid", {31'b0, m_valid_o}, 32'd0);

    // async reset after 2 load beats
    load_len_i = 13'd4; dump_len_i = 13'd0; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 32'h55;
    @(posedge clk); #1 s_data_i = 32'h66;
    @(posedge clk); #1 s_data_i = 32'h99;
    #2 rst = 1'b1;
    #1;
    chk("mrst_core_rst", {31'b0, core_rst_o}, 32'd1);
    chk("mrst_s_ready",  {31'b0, s_ready_o},  32'd0);
    chk("mrst_busy",     {31'b0, busy_o},     32'd0);
    chk("mrst_mem_we",   {28'b0, mem_we_o},   32'd0);
    chk("mrst_mem_addr", {20'b0, mem_addr_o}, 32'd0);
    chk("mrst_cksum",    cksum_o,             32'd0);
    s_valid_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    load_len_i = 13'd1; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0; s_valid_i = 1'b1; s_data_i = 32'h77;
    @(negedge clk);
    chk("restart_addr", {20'b0, mem_addr_o}, 32'd0);
    chk("restart_we",   {28'b0, mem_we_o},   32'hF);
    @(posedge clk); #1 s_valid_i = 1'b0;
    @(negedge clk);
    chk("restart_run", {31'b0, core_rst_o}, 32'd0);
`ifdef Q100_DTCM_LOADER_CKSUM_EN
    chk("restart_cksum", cksum_o, 32'h77);
`else
    chk("restart_cksum", cksum_o, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
